// File: rtl/comb_y1_pkg.sv
// Shared definitions for the 3-input truth-table function unit.
// Holds the stock truth tables and the input index type.
package comb_y1_pkg;

    // Number of select inputs and the table size they address.
    localparam int ABC_W = 3;
    localparam int TT_W  = 1 << ABC_W;

    // 3-input majority: output is 1 when at least two inputs are 1.
    localparam logic [TT_W-1:0] MAJ3_TT    = 8'b1110_1000;

    // 3-input odd parity: output is 1 when an odd number of inputs are 1.
    localparam logic [TT_W-1:0] PARITY3_TT = 8'b1001_0110;

    // Table index formed as {a,b,c}, with a as the MSB.
    typedef logic [ABC_W-1:0] abc_t;

endpackage

// File: rtl/comb_y1_lut.sv
// Purely combinational 8:1 truth-table lookup.
// The table is a parameter, so the lookup reduces to a constant mux.
module comb_y1_lut
    import comb_y1_pkg::*;
#(
    parameter logic [TT_W-1:0] TRUTH_TABLE = MAJ3_TT
) (
    input  abc_t idx,
    output logic y
);

    // Select the table bit addressed by the input code.
    always_comb begin
        y = TRUTH_TABLE[idx];
    end

endmodule

// File: rtl/comb_y1_logic.sv
// 3-input programmable function unit with a registered copy of the result.
// y is the raw combinational table output; y_q is y captured on clk.
// Optional feature macro: COMB_Y1_EDGE_DET_EN adds registered y_rise/y_fall
// pulses derived from y_q and a one-cycle delayed copy of it.
module comb_y1_logic
    import comb_y1_pkg::*;
#(
    parameter logic [TT_W-1:0] TRUTH_TABLE = MAJ3_TT,
    parameter logic            RESET_Y     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y,
`ifdef COMB_Y1_EDGE_DET_EN
    output logic y_rise,
    output logic y_fall,
`endif
    output logic y_q
);

    abc_t abc_idx;

    // Build the table index with a as the MSB and c as the LSB.
    always_comb begin
        abc_idx = {a, b, c};
    end

    comb_y1_lut #(
        .TRUTH_TABLE (TRUTH_TABLE)
    ) u_lut (
        .idx (abc_idx),
        .y   (y)
    );

    // Capture the combinational result each cycle; reset forces RESET_Y at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= RESET_Y;
        end else begin
            y_q <= y;
        end
    end

`ifdef COMB_Y1_EDGE_DET_EN
    logic y_q_d;

    // Delay y_q by a cycle and register the transition pulses from the pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_d  <= RESET_Y;
            y_rise <= 1'b0;
            y_fall <= 1'b0;
        end else begin
            y_q_d  <= y_q;
            y_rise <= y_q & ~y_q_d;
            y_fall <= ~y_q & y_q_d;
        end
    end
`endif

endmodule

// File: tb/tb_comb_y1_logic.sv
// Randomized self-checking bench for comb_y1_logic.
// Two instances: the default majority table with RESET_Y=0, and the parity
// table with RESET_Y=1. Expected values come from counting ones in the inputs.
module tb_comb_y1_logic;
    import comb_y1_pkg::*;

    logic clk;
    logic rst_n;
    logic a, b, c;
    logic y_maj, y_q_maj;
    logic y_par, y_q_par;
`ifdef COMB_Y1_EDGE_DET_EN
    logic rise_maj, fall_maj, rise_par, fall_par;
`endif

    int checks;
    int errors;

    // y_q history per instance, newest at the back; seeded with the reset value.
    logic hist_maj[$];
    logic hist_par[$];

    comb_y1_logic #(
        .TRUTH_TABLE (MAJ3_TT),
        .RESET_Y     (1'b0)
    ) dut_maj (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y_maj),
`ifdef COMB_Y1_EDGE_DET_EN
        .y_rise (rise_maj),
        .y_fall (fall_maj),
`endif
        .y_q    (y_q_maj)
    );

    comb_y1_logic #(
        .TRUTH_TABLE (PARITY3_TT),
        .RESET_Y     (1'b1)
    ) dut_par (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y_par),
`ifdef COMB_Y1_EDGE_DET_EN
        .y_rise (rise_par),
        .y_fall (fall_par),
`endif
        .y_q    (y_q_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Majority: at least two of the three inputs are 1.
    function automatic logic majRef(input logic ia, input logic ib, input logic ic);
        int n;
        n = int'(ia) + int'(ib) + int'(ic);
        return (n >= 2);
    endfunction

    // Parity: an odd number of the three inputs are 1.
    function automatic logic parRef(input logic ia, input logic ib, input logic ic);
        int n;
        n = int'(ia) + int'(ib) + int'(ic);
        return ((n % 2) == 1);
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive a new input code away from the rising edge and check y immediately.
    task automatic applyStimulus(input int code);
        @(negedge clk);
        {a, b, c} = 3'(code);
        #1;
        checkOutput("y_maj", y_maj, majRef(a, b, c));
        checkOutput("y_par", y_par, parRef(a, b, c));
    endtask

    task automatic resetHistory();
        hist_maj = '{1'b0, 1'b0};
        hist_par = '{1'b1, 1'b1};
    endtask

    // Advance one clock and check the registered outputs against the history.
    task automatic clockCycle();
        logic pre_maj, pre_par;
        pre_maj = majRef(a, b, c);
        pre_par = parRef(a, b, c);
        @(posedge clk);
        #1;
        if (rst_n) begin
            hist_maj.push_back(pre_maj);
            hist_par.push_back(pre_par);
        end
        checkOutput("y_q_maj", y_q_maj, hist_maj[$]);
        checkOutput("y_q_par", y_q_par, hist_par[$]);
`ifdef COMB_Y1_EDGE_DET_EN
        checkOutput("rise_maj", rise_maj, hist_maj[$-1] & ~hist_maj[$-2]);
        checkOutput("fall_maj", fall_maj, ~hist_maj[$-1] & hist_maj[$-2]);
        checkOutput("rise_par", rise_par, hist_par[$-1] & ~hist_par[$-2]);
        checkOutput("fall_par", fall_par, ~hist_par[$-1] & hist_par[$-2]);
`endif
        checkOutput("y_maj_hold", y_maj, majRef(a, b, c));
    endtask

    // Pull reset low between edges; registered outputs must drop at once.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        resetHistory();
        checkOutput("rst_y_q_maj", y_q_maj, 1'b0);
        checkOutput("rst_y_q_par", y_q_par, 1'b1);
        checkOutput("rst_y_maj", y_maj, majRef(a, b, c));
        checkOutput("rst_y_par", y_par, parRef(a, b, c));
`ifdef COMB_Y1_EDGE_DET_EN
        checkOutput("rst_rise", rise_maj | rise_par, 1'b0);
        checkOutput("rst_fall", fall_maj | fall_par, 1'b0);
`endif
    endtask

    // Release reset between edges; nothing changes until the next rising edge.
    task automatic releaseReset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rel_y_q_maj", y_q_maj, 1'b0);
        checkOutput("rel_y_q_par", y_q_par, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {a, b, c} = 3'b000;
        resetHistory();

        // Reset state while clock runs.
        repeat (3) clockCycle();

        // Release with ABC=011: y_q stays at reset value until first edge.
        applyStimulus(3);
        releaseReset();
        clockCycle();
        checkOutput("first_cap_maj", y_q_maj, 1'b1);
        checkOutput("first_cap_par", y_q_par, 1'b0);

        // Exhaustive ascending sweep, 100 ns per step.
        for (int code = 0; code < 8; code++) begin
            applyStimulus(code);
            repeat (10) clockCycle();
        end

        // Async reset with ABC=111 and y_q=1.
        applyStimulus(7);
        repeat (2) clockCycle();
        checkOutput("pre_rst_y_q", y_q_maj, 1'b1);
        asyncReset();
        checkOutput("rst_y_stays", y_maj, 1'b1);
        repeat (2) clockCycle();
        releaseReset();

        // Directed edge sequence 000 -> 111 -> 000.
        applyStimulus(0);
        repeat (3) clockCycle();
        applyStimulus(7);
        repeat (3) clockCycle();
        applyStimulus(0);
        repeat (3) clockCycle();

        // Random codes with random hold lengths and occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(int'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 3)) clockCycle();
            if ($urandom_range(0, 24) == 0) begin
                asyncReset();
                repeat ($urandom_range(0, 2)) clockCycle();
                releaseReset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
